// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller and datapath ALU.
package mips_pkg;

  // Sixteen states fill the 4-bit encoding exactly, so R-type and I-type
  // writeback share one state and pick RegDst from the opcode.
  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_FETCH     = 4'd1,
    S_IR_LOAD   = 4'd2,
    S_DECODE    = 4'd3,
    S_EXEC_R    = 4'd4,
    S_EXEC_I    = 4'd5,
    S_WB_ALU    = 4'd6,
    S_MEM_ADDR  = 4'd7,
    S_MEM_READ  = 4'd8,
    S_MEM_WB    = 4'd9,
    S_MEM_WRITE = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_JAL       = 4'd13,
    S_JR        = 4'd14,
    S_HALT      = 4'd15
  } state_t;

  // Opcodes (IR[31:26]) and the one funct value decoded here.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  // ALU operation codes, shared with the datapath ALU.
  localparam logic [5:0] ALU_ADDU  = 6'h21;
  localparam logic [5:0] ALU_SUBU  = 6'h23;
  localparam logic [5:0] ALU_AND   = 6'h24;
  localparam logic [5:0] ALU_OR    = 6'h25;
  localparam logic [5:0] ALU_XOR   = 6'h26;
  localparam logic [5:0] ALU_SLT   = 6'h2A;
  localparam logic [5:0] ALU_SLTU  = 6'h2B;
  localparam logic [5:0] ALU_PASSA = 6'h3E;

  // ALU_SrcB and PCSrc select encodings.
  localparam logic [1:0] SRCB_REGB   = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // Logical immediates zero-extend their imm16.
  function automatic logic is_logic_imm(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/mips_controller_alu_op_map.sv
// Maps an I-type opcode to the ALU operation used in EXEC_I.
module mips_controller_alu_op_map
  import mips_pkg::*;
(
  input  logic [5:0] i_opcode,
  output logic [5:0] o_alu_op
);

  // Pure lookup; unmapped opcodes never reach EXEC_I, ADDU is a safe filler.
  always_comb begin
    o_alu_op = ALU_ADDU;
    case (i_opcode)
      OP_ADDIU: o_alu_op = ALU_ADDU;
      OP_SLTI:  o_alu_op = ALU_SLT;
      OP_SLTIU: o_alu_op = ALU_SLTU;
      OP_ANDI:  o_alu_op = ALU_AND;
      OP_ORI:   o_alu_op = ALU_OR;
      OP_XORI:  o_alu_op = ALU_XOR;
      default:  o_alu_op = ALU_ADDU;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// Multicycle MIPS control FSM: one state per cycle, outputs decoded from the
// state register plus the registered IR fields (and alu_zero in BRANCH).
module mips_controller
  import mips_pkg::*;
#(
  parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  output logic       PCWriteCond,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemToReg,
  output logic       IRWrite,
  output logic       JumpAndLink,
  output logic       isSigned,
  output logic [1:0] PCSrc,
  output logic [5:0] ALU_Op,
  output logic       ALU_SrcA,
  output logic [1:0] ALU_SrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       halted,
  output logic [3:0] state_dbg
);

  state_t     r_state;
  state_t     w_next;
  logic [5:0] w_imm_alu_op;

  mips_controller_alu_op_map u_alu_op_map (
    .i_opcode (opcode),
    .o_alu_op (w_imm_alu_op)
  );

  assign state_dbg = r_state;

  // State register; reset aborts any instruction and parks in INIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_INIT;
    else     r_state <= w_next;
  end

  // Next-state and Moore outputs; every output defaults to idle first.
  always_comb begin
    w_next      = r_state;
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    IRWrite     = 1'b0;
    JumpAndLink = 1'b0;
    isSigned    = 1'b1;
    PCSrc       = PCSRC_ALU;
    ALU_Op      = 6'h00;
    ALU_SrcA    = 1'b0;
    ALU_SrcB    = SRCB_REGB;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_INIT: begin
        isSigned = 1'b0;
        w_next   = S_FETCH;
      end
      S_FETCH: begin
        MemRead = 1'b1;
        w_next  = S_IR_LOAD;
      end
      S_IR_LOAD: begin
        IRWrite  = 1'b1;
        ALU_SrcB = SRCB_FOUR;
        ALU_Op   = ALU_ADDU;
        PCWrite  = 1'b1;
        w_next   = S_DECODE;
      end
      S_DECODE: begin
        ALU_SrcB = SRCB_IMM_SH;
        ALU_Op   = ALU_ADDU;
        if (opcode == HALT_OPCODE) begin
          w_next = S_HALT;
        end else begin
          case (opcode)
            OP_RTYPE:       w_next = (funct == FN_JR) ? S_JR : S_EXEC_R;
            OP_LW, OP_SW:   w_next = S_MEM_ADDR;
            OP_BEQ, OP_BNE: w_next = S_BRANCH;
            OP_J:           w_next = S_JUMP;
            OP_JAL:         w_next = S_JAL;
            OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI: w_next = S_EXEC_I;
            default:        w_next = S_HALT;
          endcase
        end
      end
      S_EXEC_R: begin
        ALU_SrcA = 1'b1;
        ALU_Op   = funct;
        w_next   = S_WB_ALU;
      end
      S_EXEC_I: begin
        ALU_SrcA = 1'b1;
        ALU_SrcB = SRCB_IMM;
        ALU_Op   = w_imm_alu_op;
        isSigned = ~is_logic_imm(opcode);
        w_next   = S_WB_ALU;
      end
      S_WB_ALU: begin
        RegDst   = (opcode == OP_RTYPE);
        RegWrite = 1'b1;
        isSigned = ~is_logic_imm(opcode);
        w_next   = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALU_SrcA = 1'b1;
        ALU_SrcB = SRCB_IMM;
        ALU_Op   = ALU_ADDU;
        w_next   = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        w_next  = S_MEM_WB;
      end
      S_MEM_WB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEM_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        ALU_SrcA = 1'b1;
        ALU_Op   = ALU_SUBU;
        PCSrc    = PCSRC_ALUOUT;
        PCWrite  = (opcode == OP_BEQ) ? alu_zero : ~alu_zero;
        w_next   = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = PCSRC_JUMP;
        PCWrite = 1'b1;
        w_next  = S_FETCH;
      end
      S_JAL: begin
        PCSrc       = PCSRC_JUMP;
        PCWrite     = 1'b1;
        JumpAndLink = 1'b1;
        RegWrite    = 1'b1;
        w_next      = S_FETCH;
      end
      S_JR: begin
        ALU_SrcA = 1'b1;
        ALU_Op   = ALU_PASSA;
        PCWrite  = 1'b1;
        w_next   = S_FETCH;
      end
      S_HALT: begin
        isSigned = 1'b0;
        halted   = 1'b1;
        w_next   = S_HALT;
      end
      default: begin
        isSigned = 1'b0;
        w_next   = S_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_controller.sv
// Testbench for mips_controller: per-cycle output vectors predicted from the
// instruction class, compared cycle by cycle.
module tb_mips_controller;
  import mips_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       alu_zero = 1'b0;
  logic PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemToReg, IRWrite;
  logic JumpAndLink, isSigned, ALU_SrcA, RegWrite, RegDst, halted;
  logic [1:0] PCSrc, ALU_SrcB;
  logic [5:0] ALU_Op;
  logic [3:0] state_dbg;

  mips_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .IRWrite(IRWrite),
    .JumpAndLink(JumpAndLink), .isSigned(isSigned), .PCSrc(PCSrc), .ALU_Op(ALU_Op),
    .ALU_SrcA(ALU_SrcA), .ALU_SrcB(ALU_SrcB), .RegWrite(RegWrite), .RegDst(RegDst),
    .halted(halted), .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic       pcwc;
    logic       pcw;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       m2r;
    logic       irw;
    logic       jal;
    logic       sgn;
    logic [1:0] pcsrc;
    logic [5:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic       rw;
    logic       rd;
    logic       halt;
  } outs_t;

  logic [22:0] w_got;
  assign w_got = {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemToReg, IRWrite,
                  JumpAndLink, isSigned, PCSrc, ALU_Op, ALU_SrcA, ALU_SrcB,
                  RegWrite, RegDst, halted};

  // ---------------- scoreboard ----------------
  logic [22:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  function automatic outs_t busy();
    outs_t o = '0;
    o.sgn = 1'b1;
    return o;
  endfunction

  function automatic logic [5:0] imm_alu(input logic [5:0] op);
    case (op)
      6'h09:   return 6'h21;
      6'h0A:   return 6'h2A;
      6'h0B:   return 6'h2B;
      6'h0C:   return 6'h24;
      6'h0D:   return 6'h25;
      default: return 6'h26;
    endcase
  endfunction

  // Expected output vector for every cycle from FETCH up to the next FETCH.
  function automatic void model_instr(input logic [5:0] op, input logic [5:0] fn,
                                      input logic zero);
    outs_t o;
    logic  lg;
    lg = (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E);
    o = busy(); o.mr = 1; exp_q.push_back(o);
    o = busy(); o.irw = 1; o.srcb = 2'd1; o.aluop = 6'h21; o.pcw = 1; exp_q.push_back(o);
    o = busy(); o.srcb = 2'd3; o.aluop = 6'h21; exp_q.push_back(o);
    if (op == 6'h00 && fn == 6'h08) begin
      o = busy(); o.srca = 1; o.aluop = 6'h3E; o.pcw = 1; exp_q.push_back(o);
    end else if (op == 6'h00) begin
      o = busy(); o.srca = 1; o.aluop = fn; exp_q.push_back(o);
      o = busy(); o.rd = 1; o.rw = 1; exp_q.push_back(o);
    end else if (op == 6'h23 || op == 6'h2B) begin
      o = busy(); o.srca = 1; o.srcb = 2'd2; o.aluop = 6'h21; exp_q.push_back(o);
      if (op == 6'h23) begin
        o = busy(); o.iord = 1; o.mr = 1; exp_q.push_back(o);
        o = busy(); o.m2r = 1; o.rw = 1; exp_q.push_back(o);
      end else begin
        o = busy(); o.iord = 1; o.mw = 1; exp_q.push_back(o);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      o = busy(); o.srca = 1; o.aluop = 6'h23; o.pcsrc = 2'd1;
      o.pcw = (op == 6'h04) ? zero : !zero; exp_q.push_back(o);
    end else if (op == 6'h02 || op == 6'h03) begin
      o = busy(); o.pcsrc = 2'd2; o.pcw = 1;
      o.jal = (op == 6'h03); o.rw = (op == 6'h03); exp_q.push_back(o);
    end else if (op >= 6'h09 && op <= 6'h0E) begin
      o = busy(); o.srca = 1; o.srcb = 2'd2; o.aluop = imm_alu(op); o.sgn = !lg;
      exp_q.push_back(o);
      o = busy(); o.rw = 1; o.sgn = !lg; exp_q.push_back(o);
    end else begin
      o = '0; o.halt = 1; exp_q.push_back(o);
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Sample outputs mid-cycle, then advance to just after the next rising edge.
  task automatic sample(output logic [22:0] g, output logic [3:0] s);
    @(negedge clk);
    g = w_got;
    s = state_dbg;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_to_fetch();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    opcode = op;
    funct = fn;
    alu_zero = z;
    exp_q.delete();
    model_instr(op, fn, z);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    n_checks++;
    if (w_got !== 23'd0) begin
      n_fail++; $display("FAIL reset_outs got=%h exp=%h", w_got, 23'd0);
    end
    n_checks++;
    if (state_dbg !== 4'(S_INIT)) begin
      n_fail++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, S_INIT);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (state_dbg !== 4'(S_INIT)) begin
      n_fail++; $display("FAIL release_hold got=%0d exp=%0d", state_dbg, S_INIT);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (state_dbg !== 4'(S_FETCH)) begin
      n_fail++; $display("FAIL first_fetch got=%0d exp=%0d", state_dbg, S_FETCH);
    end
    // Mid-FETCH assertion must clear everything before any clock edge.
    rst = 1'b1;
    #1;
    n_checks++;
    if (w_got !== 23'd0 || state_dbg !== 4'(S_INIT)) begin
      n_fail++; $display("FAIL async_reset got=%h/%0d exp=0/%0d", w_got, state_dbg, S_INIT);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (state_dbg !== 4'(S_FETCH)) begin
      n_fail++; $display("FAIL refetch got=%0d exp=%0d", state_dbg, S_FETCH);
    end
  endtask

  task automatic test_sequence(input string name, input logic [5:0] op,
                               input logic [5:0] fn, input logic z);
    logic [22:0] g, e;
    logic [3:0]  s;
    int          cyc;
    drive_instr(op, fn, z);
    cyc = 0;
    while (exp_q.size() > 0) begin
      sample(g, s);
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++; $display("FAIL %s cyc%0d got=%h exp=%h", name, cyc, g, e);
      end
      if (cyc == 0) begin
        n_checks++;
        if (s !== 4'(S_FETCH)) begin
          n_fail++; $display("FAIL %s start_state got=%0d exp=%0d", name, s, S_FETCH);
        end
      end
      cyc++;
    end
    n_checks++;
    if (state_dbg !== 4'(S_FETCH)) begin
      n_fail++; $display("FAIL %s back_to_fetch got=%0d exp=%0d", name, state_dbg, S_FETCH);
    end
  endtask

  task automatic test_directed();
    test_sequence("addu", 6'h00, 6'h21, 1'b0);
    test_sequence("lw", 6'h23, 6'h00, 1'b0);
    test_sequence("sw", 6'h2B, 6'h00, 1'b1);
    test_sequence("beq_z1", 6'h04, 6'h00, 1'b1);
    test_sequence("beq_z0", 6'h04, 6'h00, 1'b0);
    test_sequence("bne_z1", 6'h05, 6'h00, 1'b1);
    test_sequence("bne_z0", 6'h05, 6'h00, 1'b0);
    test_sequence("ori", 6'h0D, 6'h00, 1'b0);
    test_sequence("addiu", 6'h09, 6'h00, 1'b0);
    test_sequence("jal", 6'h03, 6'h00, 1'b0);
    test_sequence("j", 6'h02, 6'h00, 1'b0);
    test_sequence("jr", 6'h00, 6'h08, 1'b0);
  endtask

  task automatic test_random();
    logic [5:0] ops[16];
    logic [5:0] op, fn;
    ops = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02,
            6'h03, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h23};
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 15)];
      fn = 6'($urandom_range(0, 63));
      test_sequence("rand", op, fn, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_halt(input string name, input logic [5:0] op, input int ncyc);
    logic [22:0] g, e;
    logic [3:0]  s;
    outs_t       h;
    drive_instr(op, 6'h00, 1'($urandom_range(0, 1)));
    h = '0;
    h.halt = 1;
    for (int i = 1; i < ncyc; i++) exp_q.push_back(h);
    while (exp_q.size() > 0) begin
      sample(g, s);
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++; $display("FAIL %s out got=%h exp=%h", name, g, e);
      end
      alu_zero = 1'($urandom_range(0, 1));
    end
    n_checks++;
    if (state_dbg !== 4'(S_HALT)) begin
      n_fail++; $display("FAIL %s state got=%0d exp=%0d", name, state_dbg, S_HALT);
    end
    reset_to_fetch();
    n_checks++;
    if (state_dbg !== 4'(S_FETCH)) begin
      n_fail++; $display("FAIL %s recover got=%0d exp=%0d", name, state_dbg, S_FETCH);
    end
  endtask

  // Abort a lw partway through: reset clears strobes at once and holds INIT.
  task automatic test_abort();
    logic [22:0] g, e;
    logic [3:0]  s;
    int          k;
    for (int r = 0; r < 4; r++) begin
      drive_instr(6'h23, 6'h00, 1'b0);
      k = $urandom_range(1, 5);
      for (int i = 0; i < k; i++) begin
        sample(g, s);
        e = exp_q.pop_front();
        n_checks++;
        if (g !== e) begin
          n_fail++; $display("FAIL abort_pre cyc%0d got=%h exp=%h", i, g, e);
        end
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (w_got !== 23'd0 || state_dbg !== 4'(S_INIT)) begin
        n_fail++; $display("FAIL abort_now got=%h/%0d exp=0/%0d", w_got, state_dbg, S_INIT);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (w_got !== 23'd0 || state_dbg !== 4'(S_INIT)) begin
        n_fail++; $display("FAIL abort_hold got=%h/%0d exp=0/%0d", w_got, state_dbg, S_INIT);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (state_dbg !== 4'(S_FETCH)) begin
        n_fail++; $display("FAIL abort_refetch got=%0d exp=%0d", state_dbg, S_FETCH);
      end
    end
  endtask

  // ---------------- sequencing and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_random();
    test_halt("halt_3f", 6'h3F, 100);
    test_halt("halt_3a", 6'h3A, 100);
    test_sequence("post_halt_addu", 6'h00, 6'h21, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
